// File: rtl/dcache_2way_wb.sv
// dcache_2way_wb: 2-way set-associative write-back/write-allocate L1 data cache
// with per-set LRU replacement and a line-wide refill/victim writeback port.
module dcache_2way_wb #(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 8,
  parameter int SETS       = 16,
  localparam int LINE_W    = WORD_W * LINE_WORDS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [WORD_W-1:0] p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [WORD_W-1:0] p1_data_o,
  output logic              p1_stall_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int BO_W  = $clog2(WORD_W / 8);
  localparam int WS_W  = OFF_W - BO_W;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

  typedef enum logic [2:0] {IDLE, ALLOC, WRITEBACK, REFILL, REFILL_DONE} state_e;

  state_e state_q, state_d;
  logic [SETS-1:0][1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [SETS-1:0]      lru_q, lru_d;
  logic [TAG_W-1:0]     lat_tag_q, lat_tag_d;
  logic [IDX_W-1:0]     lat_idx_q, lat_idx_d;
  logic                 victim_q, victim_d;
  logic [TAG_W-1:0]     tag_q  [SETS][2];
  logic [LINE_W-1:0]    data_q [SETS][2];

  logic [TAG_W-1:0]  c_tag, tag_d;
  logic [IDX_W-1:0]  c_idx, we_idx;
  logic [WS_W-1:0]   c_ws;
  logic [LINE_W-1:0] hit_line, line_d;
  logic hit0, hit1, hit, req, idle, wr_hit, refill, alloc_way, we, we_way, unused_lo;

  assign c_tag     = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign c_idx     = p1_addr_i[OFF_W +: IDX_W];
  assign c_ws      = p1_addr_i[BO_W +: WS_W];
  assign unused_lo = ^p1_addr_i[BO_W-1:0];
  assign hit0      = valid_q[c_idx][0] & (tag_q[c_idx][0] == c_tag);
  assign hit1      = valid_q[c_idx][1] & (tag_q[c_idx][1] == c_tag);
  assign hit       = hit0 | hit1;
  assign hit_line  = data_q[c_idx][hit1];
  assign req       = p1_MemRead_i | p1_MemWrite_i;
  assign idle      = state_q == IDLE;
  assign wr_hit    = p1_MemWrite_i & hit & idle;
  assign refill    = (state_q == REFILL) & mem_ack_i;
  // Invalid ways are filled first (way0 before way1), otherwise the LRU way.
  assign alloc_way = ~valid_q[lat_idx_q][0] ? 1'b0 : ~valid_q[lat_idx_q][1] ? 1'b1 : lru_q[lat_idx_q];

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      dirty_q   <= '0;
      lru_q     <= '0;
      lat_tag_q <= '0;
      lat_idx_q <= '0;
      victim_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      dirty_q   <= dirty_d;
      lru_q     <= lru_d;
      lat_tag_q <= lat_tag_d;
      lat_idx_q <= lat_idx_d;
      victim_q  <= victim_d;
    end

  always_ff @(posedge clk_i)
    if (we) begin
      data_q[we_idx][we_way] <= line_d;
      tag_q[we_idx][we_way]  <= tag_d;
    end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        state_d = (req & ~hit) ? ALLOC : IDLE;
      ALLOC:       state_d = (valid_q[lat_idx_q][alloc_way] & dirty_q[lat_idx_q][alloc_way]) ? WRITEBACK : REFILL;
      WRITEBACK:   state_d = mem_ack_i ? REFILL : WRITEBACK;
      REFILL:      state_d = mem_ack_i ? REFILL_DONE : REFILL;
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    lat_tag_d = idle ? c_tag : lat_tag_q;
    lat_idx_d = idle ? c_idx : lat_idx_q;
    victim_d  = (state_q == ALLOC) ? alloc_way : victim_q;
    valid_d   = valid_q;
    dirty_d   = dirty_q;
    lru_d     = lru_q;
    we        = wr_hit | refill;
    we_idx    = refill ? lat_idx_q : c_idx;
    we_way    = refill ? victim_q : hit1;
    tag_d     = refill ? lat_tag_q : c_tag;
    line_d    = refill ? mem_data_i : hit_line;
    if (idle & hit & req)
      lru_d[c_idx] = ~hit1;
    if (wr_hit) begin
      line_d[c_ws*WORD_W +: WORD_W] = p1_data_i;
      dirty_d[c_idx][hit1] = 1'b1;
    end
    if (refill) begin
      valid_d[lat_idx_q][victim_q] = 1'b1;
      dirty_d[lat_idx_q][victim_q] = 1'b0;
      lru_d[lat_idx_q] = ~victim_q;
    end
  end

  always_comb begin
    p1_stall_o   = req & ~(hit & idle);
    p1_data_o    = (p1_MemRead_i & hit) ? hit_line[c_ws*WORD_W +: WORD_W] : '0;
    mem_enable_o = (state_q == WRITEBACK) | (state_q == REFILL);
    mem_write_o  = state_q == WRITEBACK;
    mem_addr_o   = (state_q == WRITEBACK) ? {tag_q[lat_idx_q][victim_q], lat_idx_q, {OFF_W{1'b0}}} :
                   (state_q == REFILL)    ? {lat_tag_q, lat_idx_q, {OFF_W{1'b0}}} : '0;
    mem_data_o   = (state_q == WRITEBACK) ? data_q[lat_idx_q][victim_q] : '0;
  end
endmodule

// File: tb/tb_dcache_2way_wb.sv
// tb_dcache_2way_wb: directed table-driven bench for dcache_2way_wb with a
// behavioural line memory that answers requests after a programmable delay.
module tb_dcache_2way_wb;
  localparam int LINE_W = 256;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic [31:0]       p1_addr_i = '0, p1_data_i = '0, p1_data_o;
  logic              p1_MemRead_i = 1'b0, p1_MemWrite_i = 1'b0, p1_stall_o;
  logic [31:0]       mem_addr_o;
  logic [LINE_W-1:0] mem_data_o, mem_data_i;
  logic              mem_enable_o, mem_write_o, mem_ack_i;

  dcache_2way_wb dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
    .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
    .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_pass = 0;
  int ack_dly = 2, n_rf = 0, n_wb = 0;
  logic [31:0]       last_rf_addr = '0, last_wb_addr = '0;
  logic [LINE_W-1:0] last_wb_data = '0;
  logic [LINE_W-1:0] mem_m [logic [31:0]];

  task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic [LINE_W-1:0] line_of(input logic [31:0] a);
    logic [LINE_W-1:0] l;
    if (mem_m.exists(a)) return mem_m[a];
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = {a[15:0], 16'(k)};
    return l;
  endfunction

  // Memory model: captures each request, checks it stays stable while waiting,
  // and answers with a one-cycle ack ack_dly cycles after the request appears.
  initial begin
    logic              started = 1'b0, c_wr = 1'b0;
    logic [31:0]       c_addr = '0;
    logic [LINE_W-1:0] c_data = '0;
    int                cnt = 0;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      if (!mem_enable_o) started = 1'b0;
      else begin
        if (!started) begin
          started = 1'b1; cnt = 0;
          c_addr = mem_addr_o; c_wr = mem_write_o; c_data = mem_data_o;
        end else begin
          cnt++;
          chk("hold_addr", mem_addr_o, c_addr);
          chk("hold_write", mem_write_o, c_wr);
          chk("hold_data", mem_data_o, c_data);
        end
        if (cnt >= ack_dly) begin
          if (c_wr) begin
            mem_m[c_addr] = c_data; n_wb++; last_wb_addr = c_addr; last_wb_data = c_data;
          end else begin
            mem_data_i = line_of(c_addr); n_rf++; last_rf_addr = c_addr;
          end
          mem_ack_i = 1'b1;
          started = 1'b0;
        end
      end
    end
  end

  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int cyc);
    @(negedge clk_i);
    p1_addr_i = a; p1_data_i = d; p1_MemRead_i = !wr; p1_MemWrite_i = wr;
    #1;
    cyc = 0;
    while (p1_stall_o && cyc < 300) begin
      @(negedge clk_i); #1; cyc++;
    end
    if (p1_stall_o) begin
      n_chk++;
      $display("FAIL timeout addr=%0h: stall still 1 after %0d cycles, expected 0", a, cyc);
    end
    rd = p1_data_o;
    @(posedge clk_i); #1;
    p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr, wd, rd;
    int          dly, miss, wb;
    logic [31:0] raddr, wbaddr, wbw1;
  } vec_t;

  vec_t tv [19];

  initial begin
    logic [LINE_W-1:0] l100;
    logic [31:0] rd;
    int cyc, k, rf0, wb0;
    for (int i = 0; i < 8; i++) l100[i*32 +: 32] = 32'h11111111 * 32'(i + 1);
    mem_m[32'h100] = l100;
    //          wr addr      wdata         rdata         dly miss wb raddr     wbaddr  wbw1
    tv[0]  = '{1, 32'h104, 32'hDEADBEEF, 32'h0,        2, 0, 0, 32'h0,   32'h0,  32'h0};
    tv[1]  = '{0, 32'h104, 32'h0,        32'hDEADBEEF, 2, 0, 0, 32'h0,   32'h0,  32'h0};
    tv[2]  = '{0, 32'h100, 32'h0,        32'h11111111, 2, 0, 0, 32'h0,   32'h0,  32'h0};
    tv[3]  = '{0, 32'h300, 32'h0,        32'h03000000, 2, 1, 0, 32'h300, 32'h0,  32'h0};
    tv[4]  = '{0, 32'h100, 32'h0,        32'h11111111, 2, 0, 0, 32'h0,   32'h0,  32'h0};
    tv[5]  = '{0, 32'h500, 32'h0,        32'h05000000, 2, 1, 0, 32'h500, 32'h0,  32'h0};
    tv[6]  = '{0, 32'h700, 32'h0,        32'h07000000, 2, 1, 1, 32'h700, 32'h100, 32'hDEADBEEF};
    tv[7]  = '{0, 32'h104, 32'h0,        32'hDEADBEEF, 2, 1, 0, 32'h100, 32'h0,  32'h0};
    tv[8]  = '{0, 32'h300, 32'h0,        32'h03000000, 2, 1, 0, 32'h300, 32'h0,  32'h0};
    tv[9]  = '{0, 32'h11C, 32'h0,        32'h88888888, 2, 0, 0, 32'h0,   32'h0,  32'h0};
    tv[10] = '{1, 32'h000, 32'hCAFEF00D, 32'h0,        2, 1, 0, 32'h0,   32'h0,  32'h0};
    tv[11] = '{0, 32'h000, 32'h0,        32'hCAFEF00D, 2, 0, 0, 32'h0,   32'h0,  32'h0};
    tv[12] = '{1, 32'h044, 32'h1,        32'h0,        0, 1, 0, 32'h40,  32'h0,  32'h0};
    tv[13] = '{1, 32'h444, 32'h2,        32'h0,        0, 1, 0, 32'h440, 32'h0,  32'h0};
    tv[14] = '{0, 32'h840, 32'h0,        32'h08400000, 0, 1, 1, 32'h840, 32'h40, 32'h1};
    tv[15] = '{1, 32'h064, 32'h3,        32'h0,        10, 1, 0, 32'h60,  32'h0,  32'h0};
    tv[16] = '{1, 32'h464, 32'h4,        32'h0,        10, 1, 0, 32'h460, 32'h0,  32'h0};
    tv[17] = '{0, 32'h860, 32'h0,        32'h08600000, 10, 1, 1, 32'h860, 32'h60, 32'h3};
    tv[18] = '{0, 32'h464, 32'h0,        32'h4,        10, 0, 0, 32'h0,   32'h0,  32'h0};

    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_stall", p1_stall_o, 0);
    chk("rst_enable", mem_enable_o, 0);
    chk("rst_write", mem_write_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_data", p1_data_o, 0);
    @(negedge clk_i); rst_i = 1'b1;

    // Cold read of 0x100 with ack 5 cycles after the request.
    ack_dly = 5;
    @(negedge clk_i);
    p1_addr_i = 32'h100; p1_MemRead_i = 1'b1;
    #1;
    chk("cold_stall", p1_stall_o, 1);
    k = 0;
    while (!mem_enable_o && k < 20) begin @(negedge clk_i); #1; k++; end
    chk("cold_enable", mem_enable_o, 1);
    chk("cold_write", mem_write_o, 0);
    chk("cold_addr", mem_addr_o, 32'h100);
    k = 0;
    while (!mem_ack_i && k < 50) begin @(negedge clk_i); #1; k++; end
    chk("cold_ack_delay", k, 5);
    @(negedge clk_i); #1;
    chk("cold_stall_done", p1_stall_o, 1);
    @(negedge clk_i); #1;
    chk("cold_stall_fall", p1_stall_o, 0);
    chk("cold_data", p1_data_o, 32'h11111111);
    @(posedge clk_i); #1;
    p1_MemRead_i = 1'b0;

    for (int i = 0; i < 19; i++) begin
      ack_dly = tv[i].dly; rf0 = n_rf; wb0 = n_wb;
      access(tv[i].wr, tv[i].addr, tv[i].wd, rd, cyc);
      chk($sformatf("v%0d_rdata", i), rd, tv[i].rd);
      chk($sformatf("v%0d_refills", i), n_rf - rf0, tv[i].miss);
      chk($sformatf("v%0d_writebacks", i), n_wb - wb0, tv[i].wb);
      if (tv[i].miss == 0) chk($sformatf("v%0d_no_stall", i), cyc, 0);
      else chk($sformatf("v%0d_refill_addr", i), last_rf_addr, tv[i].raddr);
      if (tv[i].wb != 0) begin
        chk($sformatf("v%0d_wb_addr", i), last_wb_addr, tv[i].wbaddr);
        chk($sformatf("v%0d_wb_word1", i), last_wb_data[63:32], tv[i].wbw1);
      end
    end

    // Reset while a refill is outstanding.
    ack_dly = 20;
    @(negedge clk_i);
    p1_addr_i = 32'h900; p1_MemRead_i = 1'b1;
    k = 0;
    while (!(mem_enable_o && !mem_write_o) && k < 40) begin @(negedge clk_i); k++; end
    chk("rst_mid_enable_before", mem_enable_o, 1);
    #2; rst_i = 1'b0; #1;
    chk("rst_mid_enable_async", mem_enable_o, 0);
    chk("rst_mid_addr_async", mem_addr_o, 0);
    p1_MemRead_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    ack_dly = 1; rf0 = n_rf;
    access(0, 32'h100, 32'h0, rd, cyc);
    chk("post_rst_refills", n_rf - rf0, 1);
    chk("post_rst_refill_addr", last_rf_addr, 32'h100);
    chk("post_rst_rdata", rd, 32'h11111111);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dcache_2way_wb.md
Name: dcache_2way_wb

Overview:
- Parametrised 2-way set-associative, write-back, write-allocate L1 data cache. Next generation of the project's direct-mapped data cache.
- Sits between the pipeline MEM stage (p1_* interface) and the line-wide data memory (mem_* interface).
- Tag, valid, dirty and data storage are internal register arrays; there are no external SRAM macros.
- Adds per-set LRU replacement, configurable geometry, and a line-aligned victim writeback path.

Parameters:
- ADDR_W, 32, byte address width.
- WORD_W, 32, CPU word width in bits (must be 32 or 64).
- LINE_WORDS, 8, words per line (power of 2); line width LINE_W = WORD_W*LINE_WORDS.
- SETS, 16, number of sets (power of 2).
- Derived:
  - OFF_W = log2(LINE_W/8).
  - IDX_W = log2(SETS).
  - TAG_W = ADDR_W - IDX_W - OFF_W.
  - Word select = addr[OFF_W-1 : log2(WORD_W/8)].

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- p1_addr_i  in  ADDR_W  CPU byte address; low log2(WORD_W/8) bits ignored
- p1_data_i  in  WORD_W  CPU write data
- p1_MemRead_i  in  1  load request
- p1_MemWrite_i  in  1  store request (never asserted together with p1_MemRead_i)
- p1_data_o  out  WORD_W  load data, valid when read hit
- p1_stall_o  out  1  request not yet satisfied
- mem_addr_o  out  ADDR_W  line-aligned memory address (low OFF_W bits zero)
- mem_data_o  out  LINE_W  victim line for writeback
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  1 = writeback, 0 = refill read
- mem_data_i  in  LINE_W  refill line
- mem_ack_i  in  1  single-cycle completion pulse

Behaviour:
- Reset is rst_i, asynchronous, active-low; clock is clk_i.
- Reset clears all valid, dirty and LRU bits; data/tag arrays are not cleared. After reset:
  - state = IDLE;
  - mem_enable_o, mem_write_o, mem_addr_o, p1_stall_o = 0;
  - p1_data_o = 0.
- Hit detection is combinational: hit_w = valid[w] & tag[w] == addr tag; hit = hit_w0 | hit_w1. Both ways matching is impossible by construction.
- p1_stall_o = (p1_MemRead_i | p1_MemWrite_i) & ~(hit & state==IDLE).
- Read hit: p1_data_o = selected word of hit way, same cycle; otherwise p1_data_o = 0. At the clock edge, LRU[set] points to the non-hit way.
- Write hit (state IDLE): at the clock edge the selected word is replaced, dirty[way] = 1 and LRU is updated. Other words are unchanged.
- FSM states: IDLE, ALLOC, WRITEBACK, REFILL, REFILL_DONE.
- IDLE: a request with no hit moves to ALLOC. The address is latched; all memory-side addressing uses the latched address until IDLE is re-entered.
- ALLOC: victim selection:
  - the invalid way, way0 first;
  - otherwise way LRU[set].
  - Then assert mem_enable_o.
  - Victim valid & dirty -> WRITEBACK: mem_write_o = 1, mem_addr_o = {victim tag, index, 0}, mem_data_o = victim line.
  - Otherwise -> REFILL: mem_write_o = 0, mem_addr_o = {latched tag, index, 0}.
- WRITEBACK: hold all outputs until mem_ack_i. On ack, go to REFILL with the refill address, mem_write_o = 0 and mem_enable_o remaining 1. The victim line is held stable for the whole request.
- REFILL: on mem_ack_i:
  - write mem_data_i into the victim way;
  - valid = 1, dirty = 0, tag = latched tag;
  - deassert mem_enable_o;
  - go to REFILL_DONE.
- REFILL_DONE: one cycle, then IDLE. The still-held request then hits; a store completes as a write hit that cycle.
- mem_enable_o is never deasserted before mem_ack_i. mem_ack_i arriving in IDLE, ALLOC or REFILL_DONE is ignored.
- Ack latency from the memory is arbitrary (0 or more wait cycles beyond the request cycle).
- The CPU holds address, data and request stable while p1_stall_o = 1. If the request drops mid-miss, the miss still completes (line installed) and the FSM returns to IDLE.
- Reset mid-operation aborts any transaction immediately. mem_enable_o drops asynchronously and all lines become invalid.

Test Plan (WORD_W=32, LINE_WORDS=8, SETS=16, so index = addr[8:5]):
- Cold read 0x100 after reset:
  - stall=1;
  - mem_enable_o=1, mem_write_o=0, mem_addr_o=0x100;
  - ack after 5 cycles with line word0=0x11111111;
  - stall falls 2 cycles later, p1_data_o=0x11111111.
- Store 0x104 <- 0xDEADBEEF, then load 0x104:
  - no stall on either;
  - load returns 0xDEADBEEF.
- Fill set 8 with 0x300 (clean). Load 0x100 (LRU -> way of 0x300). Then load 0x500:
  - victim is the 0x300 way;
  - no writeback; refill address 0x500.
- Then load 0x700:
  - victim is the dirty 0x100 way;
  - WRITEBACK: mem_addr_o=0x100, mem_write_o=1, mem_data_o[63:32]=0xDEADBEEF;
  - on ack, refill 0x700 with mem_write_o=0;
  - later load 0x100 misses and refetches 0xDEADBEEF.
- Ack latency sweep: ack delay 0 and 10 cycles, both refill and writeback.
  - Outputs stay stable while waiting.
  - Exactly one refill per miss.
- Reset asserted during REFILL:
  - mem_enable_o=0 immediately;
  - after release, load 0x100 misses (line invalid) and issues a fresh refill.
